addshare_sched: RTL and testbench

Scheduler that time-shares one 12-bit Brent-Kung adder core among `NREQ` requesters. It runs a valid/ready request interface per requester, arbitrates, and registers the selected operands into the core. It captures the 13-bit sum/carry and returns it on a single tagged response channel with backpressure. It sits between the requester datapaths and the adder core (`BrentKung`: `INPUTS[2i]` = a[i], `INPUTS[2i+1]` = b[i], `OUTS[12:0]` = {carry, sum}).

---
 rtl/addshare_pkg.sv | 16 +
 rtl/addshare_if.sv | 22 ++
 rtl/BrentKung.sv | 31 +++
 rtl/addshare_arb.sv | 42 ++++
 rtl/addshare_sched.sv | 61 ++++++
 tb/tb_addshare_sched.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/addshare_pkg.sv
// addshare_pkg: shared types, widths and operand-interleave helper for the adder scheduler
// Contents: state_t (IDLE/EXEC/RESP), ADD_W, SUM_W, interleave() mapping a,b onto the core input bus.
package addshare_pkg;
    localparam int ADD_W = 12;
    localparam int SUM_W = 13;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    // Core expects a[i] at bit 2i and b[i] at bit 2i+1.
    function automatic logic [2*ADD_W-1:0] interleave(input logic [ADD_W-1:0] a, input logic [ADD_W-1:0] b);
        logic [2*ADD_W-1:0] r;
        for (int i = 0; i < ADD_W; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction
endpackage

// File: rtl/addshare_if.sv
// addshare_if: request/response bus between the requesters and addshare_sched
// Signals: req_valid/req_ready (per requester), req_a/req_b (packed 12-bit operands),
// rsp_valid/rsp_ready, rsp_id (owner tag), rsp_sum ({carry, sum}), busy.
// Modports: master (requester/consumer side), slave (scheduler side).
interface addshare_if import addshare_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [SUM_W-1:0]      rsp_sum;
    logic                  busy;
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_sum, busy);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_sum, busy);
endinterface

// File: rtl/BrentKung.sv
// BrentKung: 12-bit Brent-Kung prefix adder core, no carry-in
// Ports: INPUTS[23:0] interleaved operands (INPUTS[2i]=a[i], INPUTS[2i+1]=b[i]),
// OUTS[12:0] = {carry, sum}.
module BrentKung (
    input  logic [23:0] INPUTS,
    output logic [12:0] OUTS
);
    logic [11:0] a, b, p, g, pg;
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            a[i] = INPUTS[2*i];
            b[i] = INPUTS[2*i+1];
        end
        p  = a ^ b;
        g  = a & b;
        pg = p;
        // Up-sweep: build group generate/propagate on a binary tree.
        for (int d = 1; d < 12; d = d * 2)
            for (int i = 2*d - 1; i < 12; i = i + 2*d) begin
                g[i]  = g[i] | (pg[i] & g[i-d]);
                pg[i] = pg[i] & pg[i-d];
            end
        // Down-sweep: fill in the remaining prefixes from the tree nodes.
        for (int d = 4; d >= 1; d = d / 2)
            for (int i = 3*d - 1; i < 12; i = i + 2*d) begin
                g[i]  = g[i] | (pg[i] & g[i-d]);
                pg[i] = pg[i] & pg[i-d];
            end
        OUTS = {g[11], p ^ {g[10:0], 1'b0}};
    end
endmodule

// File: rtl/addshare_arb.sv
// addshare_arb: NREQ-wide arbiter giving a one-hot grant and its index
// Ports: clk, rst, valid (requests), en (grant taken this cycle), grant (one-hot), idx.
// ADDSHARE_RR_EN: round-robin from a pointer that moves past each taken grant;
// otherwise fixed priority with lowest index winning and no pointer register.
module addshare_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    logic [IDW-1:0] start;
`ifdef ADDSHARE_RR_EN
    logic [IDW-1:0] ptr;
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
    end
    assign start = ptr;
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, en};
    assign start = '0;
`endif
    // Scan from the far end back to start so the nearest valid requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (valid[(int'(start) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(start) + k) % NREQ] = 1'b1;
                idx = IDW'((int'(start) + k) % NREQ);
            end
    end
endmodule

// File: rtl/addshare_sched.sv
// addshare_sched: time-shares one Brent-Kung adder core among NREQ requesters
// Ports: clk, rst (sync, active-high), bus (addshare_if.slave: per-requester valid/ready
// with packed operands, tagged response with backpressure, busy).
// ADDSHARE_RR_EN selects round-robin arbitration (fixed priority when undefined).
module addshare_sched import addshare_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic      clk,
    input  logic      rst,
    addshare_if.slave bus
);
    state_t             state;
    logic [ADD_W-1:0]   a_q, b_q;
    logic [IDW-1:0]     id_q;
    logic [SUM_W-1:0]   sum_q, core_sum;
    logic [2*ADD_W-1:0] core_in;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     idx;
    logic               take, fire;
    // A grant may be issued from IDLE, or from RESP in the same cycle the result is accepted.
    assign take          = !rst && (state == IDLE || (state == RESP && bus.rsp_ready));
    assign fire          = take && |bus.req_valid;
    assign bus.req_ready = take ? grant : '0;
    assign bus.rsp_valid = state == RESP;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign core_in       = interleave(a_q, b_q);
    addshare_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (bus.req_valid),
        .en    (fire),
        .grant (grant),
        .idx   (idx)
    );
    BrentKung u_core (
        .INPUTS (core_in),
        .OUTS   (core_sum)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
            sum_q <= '0;
        end else if (fire) begin
            state <= EXEC;
            a_q   <= bus.req_a[int'(idx)*ADD_W +: ADD_W];
            b_q   <= bus.req_b[int'(idx)*ADD_W +: ADD_W];
            id_q  <= idx;
        end else if (state == EXEC) begin
            state <= RESP;
            sum_q <= core_sum;
        end else if (take) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_addshare_sched.sv
// tb_addshare_sched: randomized and directed bench for addshare_sched with an in-bench reference model
module tb_addshare_sched;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);
    logic clk = 1'b0;
    logic rst = 1'b1;
    addshare_if #(.NREQ(NREQ)) bus ();
    addshare_sched #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    // model: at most one operation owns the adder; it is answerable two cycles after its grant
    int inflight = 0, gcyc = 0, eid = 0, ptr = 0, n_rv = 0;
    logic [12:0] esum = '0;
    int gnt_q[$], gcyc_q[$], rid_q[$], rsum_q[$], rcyc_q[$];
    logic o_valid, o_busy;
    logic [12:0] o_sum;
    logic [IDW-1:0] o_id;
    logic [NREQ-1:0] o_ready;
    int exp5[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        gnt_q.delete(); gcyc_q.delete(); rid_q.delete(); rsum_q.delete(); rcyc_q.delete();
        n_rv = 0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*12 +: 12] = 12'($urandom);
            bus.req_b[i*12 +: 12] = 12'($urandom);
        end
    endtask

    // One clock: sample outputs at the falling edge, check against the model, advance it,
    // then return just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        logic ev, allowed;
        int w;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        o_valid = bus.rsp_valid;
        o_busy  = bus.busy;
        o_sum   = bus.rsp_sum;
        o_id    = bus.rsp_id;
        o_ready = bus.req_ready;
        if (rst) begin
            inflight = 0;
            ptr = 0;
        end else begin
            ev = inflight != 0 && cyc >= gcyc + 2;
            allowed = inflight == 0 || (ev && bus.rsp_ready);
            w = pick(bus.req_valid, ptr);
            eg = (allowed && w >= 0) ? NREQ'(1 << w) : '0;
            chk("req_ready", 32'(o_ready), 32'(eg));
            chk("rsp_valid", 32'(o_valid), 32'(ev));
            chk("busy", 32'(o_busy), 32'(inflight != 0));
            if (ev) begin
                chk("rsp_id", 32'(o_id), 32'(eid));
                chk("rsp_sum", 32'(o_sum), 32'(esum));
            end
            if (o_valid) n_rv++;
            if (o_ready != 0) begin
                gnt_q.push_back(oh_idx(o_ready));
                gcyc_q.push_back(cyc);
            end
            if (o_valid && bus.rsp_ready) begin
                rid_q.push_back(int'(o_id));
                rsum_q.push_back(int'(o_sum));
                rcyc_q.push_back(cyc);
            end
            if (ev && bus.rsp_ready) inflight = 0;
            if (eg != 0) begin
                inflight = 1;
                gcyc = cyc;
                eid = w;
                esum = 13'(bus.req_a[w*12 +: 12]) + 13'(bus.req_b[w*12 +: 12]);
`ifdef ADDSHARE_RR_EN
                ptr = (w + 1) % NREQ;
`endif
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        cycle();
        chk("reset rsp_valid", 32'(o_valid), 0);
        chk("reset rsp_sum", 32'(o_sum), 0);
        chk("reset rsp_id", 32'(o_id), 0);
        chk("reset busy", 32'(o_busy), 0);
        chk("reset req_ready", 32'(o_ready), 0);

        // single request with carry into bit 12
        clear_logs();
        bus.rsp_ready = 1'b1;
        bus.req_a[11:0] = 12'hFFF;
        bus.req_b[11:0] = 12'h001;
        bus.req_valid = 4'b0001;
        cycle();
        chk("t1 grant", 32'(o_ready), 32'h1);
        bus.req_valid = '0;
        bus.req_a[11:0] = 12'h123;
        repeat (4) cycle();
        chk("t1 rsp count", n_rv, 1);
        chk("t1 rsp_sum", at(rsum_q, 0), 32'h1000);
        chk("t1 rsp_id", at(rid_q, 0), 0);
        chk("t1 latency", at(rcyc_q, 0) - at(gcyc_q, 0), 2);

        // all requesters valid, back-to-back grants
        do_reset();
        clear_logs();
`ifdef ADDSHARE_RR_EN
        exp5 = '{0, 1, 2, 3, 0};
`else
        exp5 = '{0, 0, 0, 0, 0};
`endif
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            cycle();
        end
        for (int i = 0; i < 5; i++) chk("t2 grant order", at(gnt_q, i), exp5[i]);
        for (int i = 0; i < 4; i++) chk("t2 rsp order", at(rid_q, i), exp5[i]);
        chk("t2 grant spacing", at(gcyc_q, 4) - at(gcyc_q, 0), 8);
        chk("t2 rsp count", rid_q.size(), 4);
        clear_logs();
        bus.req_valid = 4'b1000;
        repeat (6) cycle();
        chk("t2 fallback grant", at(gnt_q, 0), 3);
        bus.req_valid = '0;
        repeat (3) cycle();

        // backpressure hold, then same-cycle grant on release
        clear_logs();
        bus.rsp_ready = 1'b0;
        bus.req_a[23:12] = 12'h7FF;
        bus.req_b[23:12] = 12'h801;
        bus.req_valid = 4'b0010;
        cycle();
        chk("t3 grant", 32'(o_ready), 32'h2);
        bus.req_valid = 4'b0100;
        bus.req_a[23:12] = 12'h000;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3 hold valid", 32'(o_valid), 1);
            chk("t3 hold sum", 32'(o_sum), 32'h1000);
            chk("t3 hold id", 32'(o_id), 1);
            chk("t3 hold ready", 32'(o_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        chk("t3 release grant", 32'(o_ready), 32'h4);
        bus.req_valid = '0;
        repeat (4) cycle();

        // reset while the core is executing
        clear_logs();
        rand_ops();
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t4 rsp_valid", 32'(o_valid), 0);
        chk("t4 rsp_sum", 32'(o_sum), 0);
        chk("t4 busy", 32'(o_busy), 0);
        repeat (4) cycle();
        chk("t4 no response", n_rv, 0);

        // randomized traffic
        clear_logs();
        for (int i = 0; i < 10000; i++) begin
            rand_ops();
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            bus.rsp_ready = $urandom_range(0, 9) < 7;
            cycle();
        end
        chk("t5 enough responses", 32'(rid_q.size() > 1000), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
